// File: rtl/line_follow_ctrl.sv
// Line-follower steering/drive: sensor position -> mode FSM (lost-line recovery, obstacle stop) -> per-wheel dir + PWM.
// Raw input to state_o is 3 clk; dir/duty follow the mode at the next PWM wrap, except STOP which brakes on the next clk; no backpressure.
module line_follow_ctrl #(
    parameter int N_SENS    = 3,
    parameter int PWM_BITS  = 10,
    parameter int DUTY_FAST = 900,
    parameter int DUTY_SLOW = 450,
    parameter int DUTY_TURN = 700,
    parameter int SOFT_BAND = 1,
    parameter int LOST_CYC  = 200000,
    parameter int BACK_CYC  = 300000,
    parameter int STOP_HOLD = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_SENS-1:0] sensor_i,
    input  logic              obstacle_i,
    input  logic              stop_en_i,
    output logic [1:0]        left_o,
    output logic [1:0]        right_o,
    output logic              left_pwm_o,
    output logic              right_pwm_o,
    output logic [2:0]        state_o
);

    localparam logic [2:0] ST_TURN_L   = 3'd0;
    localparam logic [2:0] ST_TURN_R   = 3'd1;
    localparam logic [2:0] ST_STRAIGHT = 3'd2;
    localparam logic [2:0] ST_SHARP_L  = 3'd3;
    localparam logic [2:0] ST_SHARP_R  = 3'd4;
    localparam logic [2:0] ST_BACK     = 3'd5;
    localparam logic [2:0] ST_STOP     = 3'd6;
    localparam logic [2:0] ST_SEARCH   = 3'd7;

    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_REV   = 2'b01;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    localparam int CNT_W  = $clog2((STOP_HOLD > BACK_CYC ? STOP_HOLD : BACK_CYC) + 1);
    localparam int LOST_W = $clog2(LOST_CYC + 1);
    localparam int DUTY_W = PWM_BITS + 1;

    // Duty is held one bit wider than pcnt so a full-scale value means constant high.
    function automatic logic [DUTY_W-1:0] sat_duty(input int duty);
        logic [DUTY_W-1:0] res;
        if (duty >= (1 << PWM_BITS)) begin
            res = DUTY_W'(1 << PWM_BITS);
        end else if (duty <= 0) begin
            res = '0;
        end else begin
            res = DUTY_W'(duty);
        end
        return res;
    endfunction

    localparam logic [DUTY_W-1:0] D_FAST = sat_duty(DUTY_FAST);
    localparam logic [DUTY_W-1:0] D_SLOW = sat_duty(DUTY_SLOW);
    localparam logic [DUTY_W-1:0] D_TURN = sat_duty(DUTY_TURN);

    logic [N_SENS-1:0]   sens_meta_q;
    logic [N_SENS-1:0]   s_sens_q;
    logic                obs_meta_q;
    logic                s_obs_q;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LOST_W-1:0]   lost_q, lost_d;
    logic                last_r_q, last_r_d;

    logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
    logic [1:0]          ldir_q, ldir_d, rdir_q, rdir_d;
    logic [DUTY_W-1:0]   lduty_q, lduty_d, rduty_q, rduty_d;
    logic                lpwm_q, lpwm_d, rpwm_q, rpwm_d;

    logic [1:0]          mode_ldir, mode_rdir;
    logic [DUTY_W-1:0]   mode_lduty, mode_rduty;

    logic                line_lost;
    logic                obs_act;
    logic [2:0]          dec_mode;
    int                  hi_idx, lo_idx, pos;

    always_comb begin
        hi_idx = 0;
        lo_idx = 0;
        for (int i = 0; i < N_SENS; i++) begin
            if (s_sens_q[i]) hi_idx = i;
        end
        for (int i = N_SENS - 1; i >= 0; i--) begin
            if (s_sens_q[i]) lo_idx = i;
        end
        // Centre of the lit span relative to the array centre; positive means the line is to the left.
        pos       = hi_idx + lo_idx - (N_SENS - 1);
        line_lost = (s_sens_q == '0);
        if (pos == 0) begin
            dec_mode = ST_STRAIGHT;
        end else if (pos > 0) begin
            dec_mode = (pos <= SOFT_BAND) ? ST_TURN_L : ST_SHARP_L;
        end else begin
            dec_mode = (pos >= -SOFT_BAND) ? ST_TURN_R : ST_SHARP_R;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = '0;
        obs_act = s_obs_q & stop_en_i;
        if (obs_act) begin
            state_d = ST_STOP;
            cnt_d   = CNT_W'(STOP_HOLD);
        end else if (state_q == ST_STOP) begin
            if (cnt_q <= CNT_W'(1)) begin
                state_d = line_lost ? ST_SEARCH : dec_mode;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (!line_lost) begin
            state_d = dec_mode;
        end else if (state_q <= ST_SHARP_R) begin
            if (lost_q >= LOST_W'(LOST_CYC - 1)) begin
                state_d = ST_BACK;
                cnt_d   = CNT_W'(BACK_CYC);
            end else begin
                lost_d = lost_q + LOST_W'(1);
            end
        end else if (state_q == ST_BACK) begin
            if (cnt_q <= CNT_W'(1)) begin
                state_d = ST_SEARCH;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        last_r_d = last_r_q;
        case (state_d)
            ST_TURN_L, ST_SHARP_L: last_r_d = 1'b0;
            ST_TURN_R, ST_SHARP_R: last_r_d = 1'b1;
            default:               last_r_d = last_r_q;
        endcase
    end

    always_comb begin
        mode_ldir  = DIR_FWD;
        mode_rdir  = DIR_FWD;
        mode_lduty = D_FAST;
        mode_rduty = D_FAST;
        case (state_d)
            ST_TURN_L: begin
                mode_lduty = D_SLOW;
            end
            ST_TURN_R: begin
                mode_rduty = D_SLOW;
            end
            ST_SHARP_L: begin
                mode_ldir  = DIR_REV;
                mode_lduty = D_TURN;
                mode_rduty = D_TURN;
            end
            ST_SHARP_R: begin
                mode_rdir  = DIR_REV;
                mode_lduty = D_TURN;
                mode_rduty = D_TURN;
            end
            ST_BACK: begin
                mode_ldir  = DIR_REV;
                mode_rdir  = DIR_REV;
                mode_lduty = D_SLOW;
                mode_rduty = D_SLOW;
            end
            ST_SEARCH: begin
                mode_ldir  = last_r_d ? DIR_FWD : DIR_REV;
                mode_rdir  = last_r_d ? DIR_REV : DIR_FWD;
                mode_lduty = D_TURN;
                mode_rduty = D_TURN;
            end
            ST_STOP: begin
                mode_ldir  = DIR_BRAKE;
                mode_rdir  = DIR_BRAKE;
                mode_lduty = '0;
                mode_rduty = '0;
            end
            default: begin
                mode_ldir  = DIR_FWD;
                mode_rdir  = DIR_FWD;
            end
        endcase
    end

    // STOP bypasses the wrap so the motors brake without finishing the current period.
    always_comb begin
        pcnt_d  = pcnt_q + PWM_BITS'(1);
        ldir_d  = ldir_q;
        rdir_d  = rdir_q;
        lduty_d = lduty_q;
        rduty_d = rduty_q;
        if (state_d == ST_STOP || pcnt_d == '0) begin
            ldir_d  = mode_ldir;
            rdir_d  = mode_rdir;
            lduty_d = mode_lduty;
            rduty_d = mode_rduty;
        end
        lpwm_d = ({1'b0, pcnt_d} < lduty_d);
        rpwm_d = ({1'b0, pcnt_d} < rduty_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sens_meta_q <= '0;
            s_sens_q    <= '0;
            obs_meta_q  <= 1'b0;
            s_obs_q     <= 1'b0;
            state_q     <= ST_STOP;
            cnt_q       <= CNT_W'(STOP_HOLD);
            lost_q      <= '0;
            last_r_q    <= 1'b0;
            pcnt_q      <= '0;
            ldir_q      <= DIR_BRAKE;
            rdir_q      <= DIR_BRAKE;
            lduty_q     <= '0;
            rduty_q     <= '0;
            lpwm_q      <= 1'b0;
            rpwm_q      <= 1'b0;
        end else begin
            sens_meta_q <= sensor_i;
            s_sens_q    <= sens_meta_q;
            obs_meta_q  <= obstacle_i;
            s_obs_q     <= obs_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lost_q      <= lost_d;
            last_r_q    <= last_r_d;
            pcnt_q      <= pcnt_d;
            ldir_q      <= ldir_d;
            rdir_q      <= rdir_d;
            lduty_q     <= lduty_d;
            rduty_q     <= rduty_d;
            lpwm_q      <= lpwm_d;
            rpwm_q      <= rpwm_d;
        end
    end

    assign left_o      = ldir_q;
    assign right_o     = rdir_q;
    assign left_pwm_o  = lpwm_q;
    assign right_pwm_o = rpwm_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed test-plan walk plus randomized sensor/obstacle traffic, checked every cycle against a timestamp-based reference model.
module tb_line_follow_ctrl;

    localparam int PB = 4;
    localparam int DF = 12;
    localparam int DS = 6;
    localparam int DT = 9;
    localparam int LC = 20;
    localparam int BC = 10;
    localparam int SH = 8;
    localparam int PERIOD = 1 << PB;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sensor;
    logic       obstacle;
    logic       stop_en;
    logic [1:0] left, right;
    logic       lpwm, rpwm;
    logic [2:0] state;

    logic [4:0] sensor5;
    logic [1:0] left5, right5;
    logic       lpwm5, rpwm5;
    logic [2:0] state5;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    line_follow_ctrl #(
        .N_SENS(3), .PWM_BITS(PB), .DUTY_FAST(DF), .DUTY_SLOW(DS), .DUTY_TURN(DT),
        .SOFT_BAND(1), .LOST_CYC(LC), .BACK_CYC(BC), .STOP_HOLD(SH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .sensor_i(sensor), .obstacle_i(obstacle), .stop_en_i(stop_en),
        .left_o(left), .right_o(right), .left_pwm_o(lpwm), .right_pwm_o(rpwm), .state_o(state)
    );

    line_follow_ctrl #(
        .N_SENS(5), .PWM_BITS(PB), .DUTY_FAST(DF), .DUTY_SLOW(DS), .DUTY_TURN(DT),
        .SOFT_BAND(1), .LOST_CYC(LC), .BACK_CYC(BC), .STOP_HOLD(SH)
    ) dut5 (
        .clk_i(clk), .rst_i(rst), .sensor_i(sensor5), .obstacle_i(1'b0), .stop_en_i(1'b0),
        .left_o(left5), .right_o(right5), .left_pwm_o(lpwm5), .right_pwm_o(rpwm5), .state_o(state5)
    );

    // Reference model: edge count, timestamps of the last obstacle/reset and BACK entry, and a run length of lost edges.
    int         cyc = 0;
    logic [2:0] sp0, sp1;
    logic       op0, op1;
    int         m_mode, stop_mark, back_mark, lost_edges;
    bit         m_right;
    int         phase;
    logic [1:0] m_ldir, m_rdir;
    int         m_lduty, m_rduty;
    logic       m_lpwm, m_rpwm;

    function automatic int decode_pos(input logic [7:0] s, input int n);
        int hi, lo, d;
        hi = -1;
        lo = -1;
        for (int i = 0; i < n; i++) begin
            if (s[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (hi < 0) return -1;
        d = hi + lo - (n - 1);
        if (d == 0) return 2;
        if (d > 1) return 3;
        if (d > 0) return 0;
        if (d < -1) return 4;
        return 1;
    endfunction

    task automatic drive_for(input int mode);
        case (mode)
            0:       begin m_ldir = 2'b10; m_rdir = 2'b10; m_lduty = DS; m_rduty = DF; end
            1:       begin m_ldir = 2'b10; m_rdir = 2'b10; m_lduty = DF; m_rduty = DS; end
            2:       begin m_ldir = 2'b10; m_rdir = 2'b10; m_lduty = DF; m_rduty = DF; end
            3:       begin m_ldir = 2'b01; m_rdir = 2'b10; m_lduty = DT; m_rduty = DT; end
            4:       begin m_ldir = 2'b10; m_rdir = 2'b01; m_lduty = DT; m_rduty = DT; end
            5:       begin m_ldir = 2'b01; m_rdir = 2'b01; m_lduty = DS; m_rduty = DS; end
            7:       drive_for(m_right ? 4 : 3);
            default: begin m_ldir = 2'b11; m_rdir = 2'b11; m_lduty = 0;  m_rduty = 0;  end
        endcase
    endtask

    task automatic model_edge();
        int dec, nxt;
        cyc++;
        if (rst) begin
            m_mode = 6; stop_mark = cyc; lost_edges = 0; m_right = 0; phase = 0;
            m_ldir = 2'b11; m_rdir = 2'b11; m_lduty = 0; m_rduty = 0; m_lpwm = 0; m_rpwm = 0;
            sp0 = 0; sp1 = 0; op0 = 0; op1 = 0;
            return;
        end
        dec = decode_pos({5'b0, sp1}, 3);
        nxt = m_mode;
        if (op1 && stop_en) begin
            nxt = 6; stop_mark = cyc; lost_edges = 0;
        end else if (m_mode == 6) begin
            if (cyc - stop_mark >= SH) nxt = (dec < 0) ? 7 : dec;
            lost_edges = 0;
        end else if (dec >= 0) begin
            nxt = dec; lost_edges = 0;
        end else if (m_mode <= 4) begin
            lost_edges++;
            if (lost_edges == LC) begin nxt = 5; back_mark = cyc; lost_edges = 0; end
        end else if (m_mode == 5) begin
            if (cyc - back_mark >= BC) nxt = 7;
        end
        if (nxt == 0 || nxt == 3) m_right = 0;
        if (nxt == 1 || nxt == 4) m_right = 1;
        m_mode = nxt;
        phase = (phase + 1) % PERIOD;
        if (nxt == 6 || phase == 0) drive_for(nxt);
        m_lpwm = (phase < m_lduty);
        m_rpwm = (phase < m_rduty);
        sp1 = sp0; sp0 = sensor; op1 = op0; op0 = obstacle;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("m_state", 32'(state), 32'(m_mode));
        check("m_left", 32'(left), 32'(m_ldir));
        check("m_right", 32'(right), 32'(m_rdir));
        check("m_lpwm", 32'(lpwm), 32'(m_lpwm));
        check("m_rpwm", 32'(rpwm), 32'(m_rpwm));
    endtask

    task automatic count_pwm(output int hl, output int hr);
        hl = 0;
        hr = 0;
        for (int i = 0; i < PERIOD; i++) begin
            tick();
            hl += int'(lpwm);
            hr += int'(rpwm);
        end
    endtask

    initial begin
        int hl, hr, r, hold;
        logic [4:0] pat5 [5];
        int         exp5 [5];
        pat5[0] = 5'b00100; exp5[0] = 2;
        pat5[1] = 5'b01100; exp5[1] = 0;
        pat5[2] = 5'b11000; exp5[2] = 3;
        pat5[3] = 5'b00011; exp5[3] = 4;
        pat5[4] = 5'b10001; exp5[4] = 2;

        rst = 1; sensor = 0; obstacle = 0; stop_en = 0; sensor5 = 0;
        @(negedge clk);
        tick(); tick();
        check("rst_state", 32'(state), 6);
        check("rst_dir", 32'({left, right}), 32'(4'b1111));
        check("rst_pwm", 32'({lpwm, rpwm}), 0);

        // Power-up hold, then straight
        rst = 0; sensor = 3'b010;
        repeat (7) tick();
        check("stop_hold_7", 32'(state), 6);
        tick();
        check("stop_exit_8", 32'(state), 2);
        repeat (PERIOD) tick();
        count_pwm(hl, hr);
        check("straight_lhi", hl, 12);
        check("straight_rhi", hr, 12);
        check("straight_dir", 32'({left, right}), 32'(4'b1010));

        // Soft then sharp left
        sensor = 3'b110;
        repeat (2) tick();
        check("turnl_lat2", 32'(state), 2);
        tick();
        check("turnl_lat3", 32'(state), 0);
        repeat (PERIOD) tick();
        count_pwm(hl, hr);
        check("turnl_lhi", hl, 6);
        check("turnl_rhi", hr, 12);
        sensor = 3'b100;
        repeat (3) tick();
        check("sharpl_state", 32'(state), 3);
        repeat (PERIOD) tick();
        count_pwm(hl, hr);
        check("sharpl_lhi", hl, 9);
        check("sharpl_rhi", hr, 9);
        check("sharpl_dir", 32'({left, right}), 32'(4'b0110));

        // Lost line after a right turn: hold, reverse, search right
        sensor = 3'b011;
        repeat (3) tick();
        check("turnr_state", 32'(state), 1);
        sensor = 3'b000;
        repeat (21) tick();
        check("lost_hold", 32'(state), 1);
        tick();
        check("back_entry", 32'(state), 5);
        repeat (9) tick();
        check("back_hold", 32'(state), 5);
        tick();
        check("search_entry", 32'(state), 7);
        repeat (PERIOD) tick();
        check("search_dir", 32'({left, right}), 32'(4'b1001));
        sensor = 3'b010;
        repeat (3) tick();
        check("reacquire", 32'(state), 2);

        // Obstacle stop, release, re-pulse reload
        repeat (PERIOD) tick();
        stop_en = 1; obstacle = 1;
        repeat (2) tick();
        check("obs_lat2", 32'(state), 2);
        tick();
        check("obs_state", 32'(state), 6);
        check("obs_dir", 32'({left, right}), 32'(4'b1111));
        check("obs_pwm", 32'({lpwm, rpwm}), 0);
        repeat (3) tick();
        obstacle = 0;
        repeat (9) tick();
        check("obs_hold", 32'(state), 6);
        tick();
        check("obs_release", 32'(state), 2);
        obstacle = 1;
        repeat (5) tick();
        obstacle = 0;
        repeat (6) tick();
        obstacle = 1;
        tick();
        obstacle = 0;
        repeat (9) tick();
        check("repulse_hold", 32'(state), 6);
        tick();
        check("repulse_release", 32'(state), 2);

        // Obstacle ignored when disabled; reset mid-BACK
        stop_en = 0; obstacle = 1;
        repeat (6) tick();
        check("obs_disabled", 32'(state), 2);
        obstacle = 0;
        sensor = 3'b000;
        repeat (22) tick();
        check("back_again", 32'(state), 5);
        repeat (3) tick();
        rst = 1;
        tick();
        check("rst_mid_state", 32'(state), 6);
        check("rst_mid_dir", 32'({left, right}), 32'(4'b1111));
        check("rst_mid_pwm", 32'({lpwm, rpwm}), 0);
        rst = 0;

        // Five-sensor decode
        sensor = 3'b010;
        sensor5 = pat5[0];
        repeat (8) tick();
        check("n5_0", 32'(state5), 32'(exp5[0]));
        for (int k = 1; k < 5; k++) begin
            sensor5 = pat5[k];
            repeat (3) tick();
            check("n5_pat", 32'(state5), 32'(exp5[k]));
        end

        // Randomized traffic
        for (int seg = 0; seg < 500; seg++) begin
            r = $urandom_range(0, 99);
            if (r < 25) sensor = 3'b000;
            else sensor = 3'($urandom_range(1, 7));
            stop_en  = ($urandom_range(0, 3) != 0);
            obstacle = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 79) == 0);
            hold = (sensor == 3'b000) ? $urandom_range(1, 50) : $urandom_range(1, 25);
            for (int t = 0; t < hold; t++) begin
                tick();
                rst = 0;
                if (obstacle && $urandom_range(0, 3) == 0) obstacle = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_follow_ctrl.md
Name: line_follow_ctrl

Overview:
- Parametrised steering and drive controller for the line-following car.
- Takes N line-tracker sensor bits and an ultrasonic obstacle flag, and produces a drive mode with H-bridge direction pairs and per-wheel PWM.
- Replaces fixed three-sensor full-speed steering with:
  - position-weighted soft and sharp turns,
  - per-mode duty cycles,
  - lost-line recovery (hold, reverse, search),
  - obstacle stop with a hold-off period.
- Sits between the sensor front ends and the motor pins in the car top level.

Parameters:
N_SENS, 3, number of tracker sensors; bit 0 = rightmost; must be ≥ 2.
PWM_BITS, 10, PWM counter width; period = 2^PWM_BITS clk cycles.
DUTY_FAST, 900, duty for the straight and outer-wheel cases (compare value).
DUTY_SLOW, 450, duty for the inner wheel on soft turns and for BACK.
DUTY_TURN, 700, duty for both wheels in SHARP and SEARCH.
SOFT_BAND, 1, largest |d| treated as a soft turn.
LOST_CYC, 200000, cycles of all-zero sensors before leaving the held mode.
BACK_CYC, 300000, cycles spent reversing in BACK.
STOP_HOLD, 1000000, cycles STOP persists after the obstacle clears.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sensor  in  N_SENS  raw tracker outputs, asynchronous, 1 = line seen
obstacle  in  1  ultrasonic "too close" flag, asynchronous
stop_en  in  1  obstacle-stop enable switch
left  out  2  left H-bridge direction: 10 fwd, 01 rev, 11 brake
right  out  2  right H-bridge direction, same encoding
left_pwm  out  1  left enable PWM
right_pwm  out  1  right enable PWM
state  out  3  current mode, for the 7-seg display

Behaviour:
- Synchronisation:
  - sensor and obstacle each pass through a 2-FF synchroniser (s_sens, s_obs).
  - Raw-to-mode latency is 3 cycles: 2 sync + 1 state register.
- Position decode (combinational on s_sens):
  - hi = index of highest set bit, lo = index of lowest set bit.
  - d = (hi + lo) − (N_SENS − 1), signed.
  - d = 0 → STRAIGHT.
  - 0 < d ≤ SOFT_BAND → TURN_L; −SOFT_BAND ≤ d < 0 → TURN_R.
  - d > SOFT_BAND → SHARP_L; d < −SOFT_BAND → SHARP_R.
  - s_sens = 0 → LOST.
- State encoding: TURN_L=0, TURN_R=1, STRAIGHT=2, SHARP_L=3, SHARP_R=4, BACK=5, STOP=6, SEARCH=7.
- last_dir register: set to L on entry to TURN_L or SHARP_L, set to R on TURN_R or SHARP_R; reset value L.
- Transitions are evaluated every cycle; first match wins:
  1. s_obs & stop_en → STOP; hold counter loaded with STOP_HOLD.
  2. STOP: decrement while !(s_obs & stop_en); at 0, go to the decoded mode (SEARCH if LOST).
  3. Decode ≠ LOST in any non-STOP state → decoded mode; lost counter cleared.
  4. LOST while in a tracking mode (0–4): stay in the current mode and increment the lost counter; at LOST_CYC → BACK, counter loaded with BACK_CYC.
  5. BACK: decrement; at 0 → SEARCH.
  6. SEARCH: stay until decode ≠ LOST (rule 3).
- Outputs per mode (dir left/right; duty left/right):
  - STRAIGHT: 10/10; FAST/FAST.
  - TURN_L: 10/10; SLOW/FAST.
  - TURN_R: 10/10; FAST/SLOW.
  - SHARP_L: 01/10; TURN/TURN.
  - SHARP_R: 10/01; TURN/TURN.
  - BACK: 01/01; SLOW/SLOW.
  - SEARCH: spin toward last_dir as SHARP_L or SHARP_R.
  - STOP: 11/11; duty 0.
- PWM generation:
  - Free-running PWM_BITS counter pcnt; xxx_pwm = (pcnt < duty_latched), registered.
  - Direction and duty are latched only when pcnt wraps to 0, so no mid-period glitches.
  - Exception: entry to STOP forces left = right = 11 and both PWMs to 0 on the next clk, with no wait for the wrap.
  - Duty ≥ 2^PWM_BITS gives constant high; duty 0 gives constant low.
- Reset:
  - state = STOP with the hold counter loaded with STOP_HOLD, so motors stay braked for STOP_HOLD after reset.
  - left = right = 11, pwm outputs 0, pcnt 0, lost counter 0, last_dir L, synchronisers 0.
  - Reset mid-operation takes effect on the next clk edge, overriding every other rule.
- Simultaneous events:
  - Obstacle plus a line change in the same cycle → STOP.
  - Obstacle asserted while stop_en = 0 → ignored.
  - Obstacle re-asserted during the STOP hold → counter reloads.

Test Plan:
Use PWM_BITS=4, DUTY_FAST=12, DUTY_SLOW=6, DUTY_TURN=9, LOST_CYC=20, BACK_CYC=10, STOP_HOLD=8, N_SENS=3.
1. Reset, then sensor=010, obstacle=0 → STOP for 8 cycles, then state=2; left=right=10; both PWMs high 12 of 16 cycles once latched.
2. sensor 010→110 → state=0 three cycles later; at the next wrap, left_pwm high 6/16 and right_pwm high 12/16. Then 100 → state=3, left=01, right=10, both high 9/16.
3. After TURN_R, sensor=000 → state=1 held for 20 cycles; then BACK (5), left=right=01 for 10 cycles; then SEARCH (7) spinning right. sensor=010 → state=2.
4. Mid-straight, obstacle=1, stop_en=1 → next cycle after sync: state=6, left=right=11, PWMs 0 immediately. Obstacle drops → exit STOP exactly 8 cycles later. Re-pulse at count 4 → full 8 again.
5. obstacle=1, stop_en=0 → no state change. Assert rst mid-BACK → STOP/11/0 on next edge.
6. N_SENS=5, SOFT_BAND=1: sensor 00100 → 2; 01100 → 0; 11000 → 3; 00011 → 4; 10001 → 2.
